// File: rtl/sqrt_seq_pipe.sv
// -----------------------------------------------------------------------------
// sqrt_seq_pipe
// Sequential fixed-point square root, one result bit per clock, restoring
// digit recurrence (compare/subtract only). The radicand is the integer input
// scaled by 2^(2*FRAC_W), so the root carries FRAC_W fractional bits.
//
// Ports
//   clk          in   1        clock, all state on rising edge
//   rst_n        in   1        asynchronous active-low reset
//   i_in_valid   in   1        radicand offered
//   o_in_ready   out  1        unit can accept a radicand (IDLE)
//   i_in         in   IN_W     unsigned radicand
//   o_out_valid  out  1        result available (DONE)
//   i_out_ready  in   1        downstream accepts result
//   o_out        out  OUT_W    root, FRAC_W fractional bits (rounded if ROUND=1)
//   o_out_rem    out  OUT_W+1  (i_in << 2*FRAC_W) - truncated_root^2
// -----------------------------------------------------------------------------
module sqrt_seq_pipe #(
    parameter int IN_W   = 8,
    parameter int FRAC_W = 8,
    parameter int ROUND  = 0,
    localparam int RAD_W = IN_W + 2 * FRAC_W,
    localparam int OUT_W = (RAD_W + 1) / 2,
    localparam int CNT_W = $clog2(OUT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [IN_W-1:0]  i_in,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [OUT_W-1:0] o_out,
    output logic [OUT_W:0]   o_out_rem
);

    // Radicand width rounded up to even so two bits can be consumed per step.
    localparam int PAD_W = 2 * OUT_W;

    if (IN_W < 2 || FRAC_W < 0) begin : g_bad_param
        $error("sqrt_seq_pipe: IN_W must be >= 2 and FRAC_W >= 0");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PAD_W-1:0]   r_rad;
    logic [OUT_W-1:0]   r_root;
    logic [OUT_W+1:0]   r_rem;
    logic [CNT_W-1:0]   r_cnt;
    logic [OUT_W-1:0]   r_out;
    logic [OUT_W:0]     r_out_rem;
    logic               r_in_ready;
    logic               r_out_valid;

    logic               w_accept;
    logic [PAD_W-1:0]   w_rad_load;
    logic [OUT_W+1:0]   w_t;
    logic [OUT_W+1:0]   w_q;
    logic               w_ge;
    logic [OUT_W+1:0]   w_rem_nxt;
    logic [OUT_W-1:0]   w_root_nxt;
    logic               w_rnd_up;
    logic [OUT_W-1:0]   w_out_fin;

    assign w_accept   = i_in_valid & r_in_ready;
    // Zero-extend to the even working width, then apply the fractional scaling.
    assign w_rad_load = PAD_W'(i_in) << (2 * FRAC_W);

    // One recurrence step: bring down two radicand bits, try subtracting 4*root+1.
    // The previous remainder never exceeds OUT_W bits, so the shift loses nothing.
    assign w_t        = (r_rem << 2) | {OUT_W'(0), r_rad[PAD_W-1 -: 2]};
    assign w_q        = {r_root, 2'b01};
    assign w_ge       = (w_t >= w_q);
    assign w_rem_nxt  = w_ge ? (w_t - w_q) : w_t;
    assign w_root_nxt = (r_root << 1) | OUT_W'(w_ge);

    // rem > root  <=>  radicand >= (root + 0.5)^2, i.e. nearest is root+1.
    assign w_rnd_up   = (ROUND != 0) && (w_rem_nxt > {2'b00, w_root_nxt});
    assign w_out_fin  = !w_rnd_up       ? w_root_nxt :
                        (&w_root_nxt)   ? {OUT_W{1'b1}} :
                                          (w_root_nxt + OUT_W'(1));

    // Next-state logic for the IDLE -> CALC -> DONE -> IDLE sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_CALC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                if (r_cnt == CNT_W'(0)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_CALC;
                end
            end
            S_DONE: begin
                if (r_out_valid && i_out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register plus handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
        end
    end

    // Datapath: load on accept, iterate in CALC, capture result on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rad     <= '0;
            r_root    <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_out     <= '0;
            r_out_rem <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rad  <= w_rad_load;
                        r_root <= '0;
                        r_rem  <= '0;
                        r_cnt  <= CNT_W'(OUT_W - 1);
                    end
                end
                S_CALC: begin
                    r_rad  <= r_rad << 2;
                    r_root <= w_root_nxt;
                    r_rem  <= w_rem_nxt;
                    if (r_cnt == CNT_W'(0)) begin
                        r_out     <= w_out_fin;
                        r_out_rem <= w_rem_nxt[OUT_W:0];
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out       = r_out;
    assign o_out_rem   = r_out_rem;

endmodule

// File: tb/tb_sqrt_seq_pipe.sv
// Bench for sqrt_seq_pipe: directed cases plus a full sweep of all 8-bit
// radicands with random output stalls, checked against an arithmetic model.
module tb_sqrt_seq_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_d = 8'd0;

    logic        a_in_ready, a_out_valid;
    logic [11:0] a_out;
    logic [12:0] a_rem;
    logic        b_in_ready, b_out_valid;
    logic [11:0] b_out;
    logic [12:0] b_rem;

    logic        c_in_valid = 1'b0;
    logic        c_out_ready = 1'b0;
    logic [7:0]  c_in = 8'd0;
    logic        c_in_ready, c_out_valid;
    logic [3:0]  c_out;
    logic [4:0]  c_rem;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sqrt_seq_pipe #(.IN_W(8), .FRAC_W(8), .ROUND(0)) u_trunc (
        .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(a_in_ready),
        .i_in(in_d), .o_out_valid(a_out_valid), .i_out_ready(out_ready),
        .o_out(a_out), .o_out_rem(a_rem));

    sqrt_seq_pipe #(.IN_W(8), .FRAC_W(8), .ROUND(1)) u_round (
        .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(b_in_ready),
        .i_in(in_d), .o_out_valid(b_out_valid), .i_out_ready(out_ready),
        .o_out(b_out), .o_out_rem(b_rem));

    sqrt_seq_pipe #(.IN_W(8), .FRAC_W(0), .ROUND(1)) u_int (
        .clk(clk), .rst_n(rst_n), .i_in_valid(c_in_valid), .o_in_ready(c_in_ready),
        .i_in(c_in), .o_out_valid(c_out_valid), .i_out_ready(c_out_ready),
        .o_out(c_out), .o_out_rem(c_rem));

    function automatic longint isqrt(input longint n);
        longint r;
        longint c;
        r = 0;
        for (int k = 15; k >= 0; k--) begin
            c = r + (longint'(1) << k);
            if (c * c <= n) r = c;
        end
        return r;
    endfunction

    // Nearest root: round up when 4n exceeds (2r+1)^2, saturate at 12 bits.
    function automatic longint round_root(input longint n, input longint maxv);
        longint r;
        r = isqrt(n);
        if (4 * n > (2 * r + 1) * (2 * r + 1)) r = r + 1;
        if (r > maxv) r = maxv;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [7:0] v);
        int w;
        w = 0;
        @(negedge clk);
        while (!a_in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_wait", 32'(a_in_ready), 32'd1);
        in_d = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_d = 8'($urandom);
        chk("busy_after_accept", 32'(a_in_ready), 32'd0);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!a_out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_one(input logic [7:0] v, input int stall_max);
        int lat;
        int stall;
        longint n;
        longint r;
        n = longint'(v) << 16;
        r = isqrt(n);
        accept(v);
        wait_done(lat);
        chk("latency", 32'(lat), 32'd12);
        chk("round_valid", 32'(b_out_valid), 32'd1);
        stall = $urandom_range(0, stall_max);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 32'(a_out_valid), 32'd1);
        end
        chk("trunc_out", 32'(a_out), 32'(r));
        chk("trunc_rem", 32'(a_rem), 32'(n - r * r));
        chk("identity", 32'(longint'(a_rem) + longint'(a_out) * longint'(a_out)), 32'(n));
        chk("round_out", 32'(b_out), 32'(round_root(n, 4095)));
        chk("round_rem", 32'(b_rem), 32'(n - r * r));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("valid_drop", 32'(a_out_valid), 32'd0);
        chk("ready_back", 32'(a_in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int start;
        logic [7:0] val;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out", 32'(a_out), 32'd0);
        chk("rst_rem", 32'(a_rem), 32'd0);
        chk("rst_int_ready", 32'(c_in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // T1..T3 directed values with spec constants
        run_one(8'd4, 0);
        chk("t1_out", 32'(a_out), 32'h200);
        chk("t1_rem", 32'(a_rem), 32'd0);
        run_one(8'd2, 0);
        chk("t2_out", 32'(a_out), 32'h16A);
        chk("t2_rem", 32'(a_rem), 32'd28);
        run_one(8'd0, 2);
        chk("t2_zero_out", 32'(a_out), 32'd0);
        chk("t2_zero_rem", 32'(a_rem), 32'd0);
        run_one(8'd255, 0);
        chk("t3_out", 32'(a_out), 32'hFF7);
        chk("t3_rem", 32'(a_rem), 32'd8111);
        chk("t3_round", 32'(b_out), 32'hFF8);

        // T4 integer-only root with rounding saturation
        @(negedge clk);
        c_in = 8'd255;
        c_in_valid = 1'b1;
        @(posedge clk);
        #1;
        c_in_valid = 1'b0;
        lat = 0;
        while (!c_out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("t4_latency", 32'(lat), 32'd4);
        chk("t4_out", 32'(c_out), 32'hF);
        chk("t4_rem", 32'(c_rem), 32'd30);
        c_out_ready = 1'b1;
        @(posedge clk);
        #1;
        c_out_ready = 1'b0;
        chk("t4_drop", 32'(c_out_valid), 32'd0);

        // T5 long back-pressure with ignored input pulses
        accept(8'd100);
        wait_done(lat);
        chk("t5_latency", 32'(lat), 32'd12);
        for (int k = 0; k < 20; k++) begin
            in_valid = k[0];
            in_d = 8'($urandom);
            @(posedge clk);
            #1;
            chk("t5_out", 32'(a_out), 32'd2560);
            chk("t5_busy", 32'(a_in_ready), 32'd0);
            chk("t5_valid", 32'(a_out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("t5_ready", 32'(a_in_ready), 32'd1);
        in_d = 8'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("t5_accepted", 32'(a_in_ready), 32'd0);
        wait_done(lat);
        chk("t5_next_latency", 32'(lat), 32'd12);
        chk("t5_next_out", 32'(a_out), 32'h300);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // T6 asynchronous abort in the middle of the iteration
        accept(8'd200);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(a_out_valid), 32'd0);
        chk("t6_ready", 32'(a_in_ready), 32'd1);
        chk("t6_out", 32'(a_out), 32'd0);
        chk("t6_rem", 32'(a_rem), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_one(8'd9, 0);
        chk("t6_new_out", 32'(a_out), 32'h300);

        // Full sweep in a random permutation with random stalls
        start = $urandom_range(0, 255);
        for (int i = 0; i < 256; i++) begin
            val = 8'((start + i * 73) % 256);
            run_one(val, 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
